mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the multicycle core's unified instruction/data memory port.
//   Accepts one read or write request at a time over a valid/ready handshake.
//   Inserts WAIT_CYCLES of latency, then returns a one-cycle response carrying read data and an error flag.
//   Sits between the core datapath (memory address/data mux, we_mem) and a single-port word RAM.
// PARAMETERS
//   ADDR_W       32   byte-address width of req_addr
//   DATA_W       32   word width; fixed at 32 for RV32
//   DEPTH_WORDS  256  RAM depth in 32-bit words
//   WAIT_CYCLES  1    extra cycles between accept and response (0..15)
// PORTS
//   clk        in   1       clock; all state updates on posedge
//   rst        in   1       async reset, active-low
//   req_valid  in   1       core presents a request
//   req_we     in   1       1 = write, 0 = read
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   DATA_W  write data
//   req_ready  out  1       responder can accept a request this cycle
//   rsp_valid  out  1       one-cycle response strobe
//   rsp_rdata  out  DATA_W  read data; valid with rsp_valid on a read
//   rsp_err    out  1       request was misaligned or out of range
// BEHAVIOUR
//   Clock/reset: one clock (clk); reset rst is asynchronous and active-low.
//   Reset state: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
//     RAM contents are not reset.
//   Handshake:
//     A request is accepted on the posedge where req_valid && req_ready.
//     addr/we/wdata are captured into registers at accept; inputs are ignored afterwards.
//     req_ready=1 only in IDLE. The core must hold req_valid until it is accepted.
//   FSM:
//     IDLE -> WAIT on accept (WAIT_CYCLES>0); IDLE -> RESP on accept (WAIT_CYCLES==0).
//     WAIT: counter loads WAIT_CYCLES-1 at accept and decrements; WAIT -> RESP when counter==0.
//     RESP: rsp_valid=1 for exactly one cycle; RESP -> IDLE unconditionally.
//   Latency: rsp_valid is high exactly WAIT_CYCLES+1 cycles after the accept edge.
//     Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
//   Error check (captured request):
//     err = (addr[1:0]!=0) || (addr[ADDR_W-1:2] >= DEPTH_WORDS).
//     On err: no RAM write, rsp_rdata=0, rsp_err=1 during RESP.
//   Write: RAM word addr[..:2] is written on the edge entering RESP. rsp_rdata is unchanged by writes.
//   Read: rsp_rdata is registered on the edge entering RESP and holds until the next response.
//     A read following a write to the same word returns the new data.
//   rsp_err is registered with rsp_rdata, is meaningful only while rsp_valid=1, and is cleared on leaving RESP.
//   Reset mid-operation: FSM returns to IDLE immediately.
//     A pending write not yet committed (still in WAIT) is dropped; no rsp_valid is produced for it.
//   req_valid asserted in WAIT/RESP: ignored (req_ready=0); no request is lost, since the core holds it.
//   Unknown states decode to IDLE.
// STRUCTURE
//   Shared defines header: FSM state encodings (MR_IDLE/MR_WAIT/MR_RESP, 2 bits) and the word-offset width.
//   Sub-module sp_ram: single-port synchronous word RAM.
//     Ports: clk, we, addr, wdata, rdata. Depth DEPTH_WORDS; read data registered.
//   mem_responder owns only the FSM, capture registers, wait counter and error logic.
// TESTING
//   Reset: hold rst=0 3 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//     Release rst -> outputs unchanged until a request arrives.
//   Write then read (WAIT_CYCLES=1): write 0xDEADBEEF @0x10, then read @0x10.
//     -> each rsp_valid exactly 2 cycles after accept; read returns 0xDEADBEEF, rsp_err=0.
//   Errors: read @0x13 -> rsp_err=1, rsp_rdata=0.
//     Write 0x1 @0x400 (DEPTH_WORDS=256) -> rsp_err=1; a following read @0x0 is unaffected.
//   Busy hold: keep req_valid=1 continuously with 3 queued reads.
//     -> req_ready pulses once per 3 cycles; 3 rsp_valid pulses, in order, with the correct data.
//   Zero wait (WAIT_CYCLES=0): read @0x4 -> rsp_valid exactly 1 cycle after accept.
//   Reset mid-op (WAIT_CYCLES=3): accept write 0x55 @0x8, assert rst in WAIT.
//     -> no rsp_valid; a later read @0x8 returns the old value.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared definitions for the memory responder slice: FSM state encodings,
//   the byte-offset width inside a 32-bit word, and the wait counter width.
//   There are no ports; mem_responder imports it with import mem_responder_pkg::*.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_WAIT = 2'd1,
        MR_RESP = 2'd2
    } mr_state_t;

    // Byte-offset bits below the word index (32-bit words).
    localparam int MR_WORD_OFFSET_W = 2;

    // Wait counter width; covers WAIT_CYCLES up to 15.
    localparam int MR_CNT_W = 4;

endpackage

// File: rtl/mem_responder_sp_ram.sv
// sp_ram
//   Single-port synchronous word RAM. There is one shared address for the read
//   and the write. Read data is registered, so it appears the cycle after the
//   address is presented. When a write and a read hit the same address on one
//   edge, the read returns the old contents. The memory array has no reset.
// Ports
//   clk    in   clock
//   we     in   write enable for the word at addr
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data of the word at addr
module sp_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_W      = 32,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multicycle core's unified memory port.
//   It accepts one read or write request at a time over a valid/ready handshake.
//   It then waits WAIT_CYCLES cycles and returns a one-cycle response that
//   carries read data and an error flag. It owns the FSM, the capture
//   registers, the wait counter and the address checking. The storage is in
//   sp_ram.
// Ports
//   clk        in   clock, posedge
//   rst        in   asynchronous reset, active-low
//   req_valid  in   core presents a request (held until accepted)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   req_ready  out  request can be accepted this cycle (IDLE only)
//   rsp_valid  out  one-cycle response strobe
//   rsp_rdata  out  read data; held until the next response
//   rsp_err    out  misaligned or out-of-range request, valid with rsp_valid
//
// state   | meaning
// MR_IDLE | ready for a request; accepts it on req_valid
// MR_WAIT | latency cycles; the RAM access is issued when the counter reaches 0
// MR_RESP | rsp_valid high for this single cycle
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int RAM_AW = $clog2(DEPTH_WORDS);
    localparam logic [MR_CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? MR_CNT_W'(WAIT_CYCLES - 1) : '0;

    mr_state_t           state;
    logic [MR_CNT_W-1:0] cnt;
    logic [RAM_AW-1:0]   cap_word;
    logic                cap_we;
    logic                cap_err;
    logic [DATA_W-1:0]   cap_wdata;
    logic [DATA_W-1:0]   rdata_hold;
    logic [DATA_W-1:0]   ram_rdata;

    logic                accept;
    logic                issue;
    logic                issue_we;
    logic                issue_err;
    logic [RAM_AW-1:0]   issue_word;
    logic [DATA_W-1:0]   issue_wdata;
    logic                ram_we;

    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[MR_WORD_OFFSET_W-1:0] != '0) ||
               ({{MR_WORD_OFFSET_W{1'b0}}, a[ADDR_W-1:MR_WORD_OFFSET_W]} >=
                ADDR_W'(DEPTH_WORDS));
    endfunction

    // The rst term keeps a zero-wait request from writing the RAM while reset is held.
    assign accept = req_valid && req_ready && rst;

    // The RAM is accessed on the edge that enters RESP. With zero wait, that
    // edge is the accept edge, so the live request drives the RAM directly.
    always_comb begin
        issue       = 1'b0;
        issue_we    = cap_we;
        issue_err   = cap_err;
        issue_word  = cap_word;
        issue_wdata = cap_wdata;
        if (state == MR_IDLE) begin
            issue_we    = req_we;
            issue_err   = addr_err(req_addr);
            issue_word  = req_addr[RAM_AW+MR_WORD_OFFSET_W-1:MR_WORD_OFFSET_W];
            issue_wdata = req_wdata;
            issue       = accept && (WAIT_CYCLES == 0);
        end else if (state == MR_WAIT) begin
            issue = (cnt == '0);
        end
    end

    assign ram_we = issue && issue_we && !issue_err;

    sp_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .DATA_W     (DATA_W),
        .AW         (RAM_AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (issue_word),
        .wdata(issue_wdata),
        .rdata(ram_rdata)
    );

    // The RAM output is live only during RESP. At all other times the last
    // response is replayed from rdata_hold. A write response leaves the read
    // data unchanged.
    always_comb begin
        rsp_rdata = rdata_hold;
        if (state == MR_RESP) begin
            if (rsp_err) begin
                rsp_rdata = '0;
            end else if (!cap_we) begin
                rsp_rdata = ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= MR_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rdata_hold <= '0;
            cap_word   <= '0;
            cap_we     <= 1'b0;
            cap_err    <= 1'b0;
            cap_wdata  <= '0;
        end else begin
            case (state)
                MR_IDLE: begin
                    if (accept) begin
                        cap_word  <= issue_word;
                        cap_we    <= req_we;
                        cap_err   <= issue_err;
                        cap_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state     <= MR_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= issue_err;
                        end else begin
                            state <= MR_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                MR_WAIT: begin
                    if (cnt == '0) begin
                        state     <= MR_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= cap_err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MR_RESP: begin
                    state      <= MR_IDLE;
                    rsp_valid  <= 1'b0;
                    rsp_err    <= 1'b0;
                    req_ready  <= 1'b1;
                    rdata_hold <= rsp_rdata;
                end
                default: begin
                    state     <= MR_IDLE;
                    cnt       <= '0;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Three responders share one clock and one reset: WAIT_CYCLES = 0, 1 and 3.
//   The reference model is a word array per instance plus the last returned
//   read data. Expected latency, error flag and data come from the address
//   rules applied with plain arithmetic.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [2:0]       rv, rwe, rdy, vld, er;
    logic [2:0][31:0] ra, rwd, rd;

    int checks   = 0;
    int failures = 0;

    int          wc [3] = '{0, 1, 3};
    logic [31:0] mdl [3][256];
    bit          known [3][256];
    logic [31:0] hold [3];

    mem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_we(rwe[0]), .req_addr(ra[0]),
        .req_wdata(rwd[0]), .req_ready(rdy[0]), .rsp_valid(vld[0]), .rsp_rdata(rd[0]),
        .rsp_err(er[0]));
    mem_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_we(rwe[1]), .req_addr(ra[1]),
        .req_wdata(rwd[1]), .req_ready(rdy[1]), .rsp_valid(vld[1]), .rsp_rdata(rd[1]),
        .rsp_err(er[1]));
    mem_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_we(rwe[2]), .req_addr(ra[2]),
        .req_wdata(rwd[2]), .req_ready(rdy[2]), .rsp_valid(vld[2]), .rsp_rdata(rd[2]),
        .rsp_err(er[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk1({tag, " ready"}, rdy[i], 1'b1);
            chk1({tag, " valid"}, vld[i], 1'b0);
            chk ({tag, " rdata"}, rd[i], hold[i]);
            chk1({tag, " err"},   er[i], 1'b0);
        end
    endtask

    // Issue one request on instance i. Entered and left at a negedge.
    task automatic do_req(input int i, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        bit          e;
        int          n;
        logic [31:0] exp_rd;
        e = (addr % 4 != 0) || (addr / 4 >= 256);
        if (e)       exp_rd = 32'h0;
        else if (we) exp_rd = hold[i];
        else         exp_rd = mdl[i][addr / 4];
        rv[i] = 1'b1; rwe[i] = we; ra[i] = addr; rwd[i] = wdata;
        n = 0;
        while (!rdy[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, " accept"}, rdy[i], 1'b1);
        @(negedge clk);
        // Scramble the inputs after the accept; the captured request must be used.
        rv[i] = 1'b0; rwe[i] = 1'($urandom); ra[i] = $urandom; rwd[i] = $urandom;
        for (int k = 1; k <= wc[i]; k++) begin
            chk1({tag, " early"}, vld[i], 1'b0);
            @(negedge clk);
        end
        chk1({tag, " valid"}, vld[i], 1'b1);
        chk1({tag, " busy"},  rdy[i], 1'b0);
        chk ({tag, " rdata"}, rd[i],  exp_rd);
        chk1({tag, " err"},   er[i],  e);
        @(negedge clk);
        chk1({tag, " pulse"}, vld[i], 1'b0);
        chk1({tag, " errclr"}, er[i], 1'b0);
        chk ({tag, " rdhold"}, rd[i], exp_rd);
        if (!e && we) begin
            mdl[i][addr / 4]   = wdata;
            known[i][addr / 4] = 1'b1;
        end
        hold[i] = exp_rd;
    endtask

    initial begin
        logic [31:0] old8, d;
        logic [31:0] q_exp [$];
        int          acc_cyc [$];
        int          nresp, idx;
        rst = 1'b0; rv = '0; rwe = '0; ra = '0; rwd = '0;
        for (int i = 0; i < 3; i++) hold[i] = 32'h0;

        // Reset state, then unchanged after release
        repeat (3) @(negedge clk);
        idle_outputs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        idle_outputs("post_reset");

        // Write then read, one wait cycle
        do_req(1, 1'b1, 32'h10, 32'hDEADBEEF, "w1_wr10");
        do_req(1, 1'b0, 32'h10, 32'h0, "w1_rd10");
        // Errors
        do_req(1, 1'b0, 32'h13, 32'h0, "w1_rd13_err");
        do_req(1, 1'b1, 32'h0, 32'h0BADF00D, "w1_wr0");
        do_req(1, 1'b1, 32'h400, 32'h1, "w1_wr400_err");
        do_req(1, 1'b0, 32'h0, 32'h0, "w1_rd0");
        do_req(1, 1'b1, 32'h3FC, 32'hA5A5_0FF0, "w1_wr_last");
        do_req(1, 1'b0, 32'h3FC, 32'h0, "w1_rd_last");
        do_req(1, 1'b0, 32'h400, 32'h0, "w1_rd400_err");

        // Zero wait
        do_req(0, 1'b1, 32'h4, $urandom, "w0_wr4");
        do_req(0, 1'b0, 32'h4, 32'h0, "w0_rd4");

        // Busy hold: req_valid stays high across three queued reads
        for (int w = 20; w < 23; w++) do_req(1, 1'b1, w * 4, $urandom, "w1_prefill");
        nresp = 0; idx = 0;
        rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = 32'd80;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (vld[1]) begin
                if (q_exp.size() > 0) chk("busy rdata", rd[1], q_exp.pop_front());
                else                  chk("busy extra_rsp", 32'(nresp), 32'd3);
                chk1("busy err", er[1], 1'b0);
                nresp++;
            end
            if (rv[1] && rdy[1]) begin
                acc_cyc.push_back(cyc);
                q_exp.push_back(mdl[1][20 + idx]);
                idx++;
            end
            @(negedge clk);
            if (idx >= 3) rv[1] = 1'b0;
            else          ra[1] = 32'((20 + idx) * 4);
        end
        rv[1] = 1'b0;
        chk("busy responses", 32'(nresp), 32'd3);
        if (acc_cyc.size() == 3) begin
            chk("busy spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("busy spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end else begin
            chk("busy accepts", 32'(acc_cyc.size()), 32'd3);
        end
        hold[1] = mdl[1][22];

        // Reset while a write is still waiting
        old8 = $urandom;
        do_req(2, 1'b1, 32'h8, old8, "w3_wr8_old");
        rv[2] = 1'b1; rwe[2] = 1'b1; ra[2] = 32'h8; rwd[2] = 32'h55;
        chk1("midrst accept", rdy[2], 1'b1);
        @(negedge clk);
        rv[2] = 1'b0;
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk1("midrst in_reset valid", vld[2], 1'b0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) hold[i] = 32'h0;
        repeat (6) begin
            @(negedge clk);
            chk1("midrst no_rsp", vld[2], 1'b0);
            chk1("midrst ready", rdy[2], 1'b1);
        end
        do_req(2, 1'b0, 32'h8, 32'h0, "w3_rd8_old");

        // Random traffic on every instance
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 15; n++) begin
                int          kind;
                bit          we;
                logic [31:0] a;
                kind = $urandom_range(0, 7);
                a    = 32'($urandom_range(0, 15) * 4);
                if (kind == 0)      a = a + 32'($urandom_range(1, 3));
                else if (kind == 1) a = 32'($urandom_range(256, 1000) * 4);
                else if (kind == 2) a = 32'hFFFF_FFF0;
                we = 1'($urandom_range(0, 1));
                if (!we && a % 4 == 0 && a / 4 < 256 && !known[i][a / 4]) we = 1'b1;
                d = $urandom;
                do_req(i, we, a, d, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
